// File: rtl/alu_issue_pkg.sv
// Shared ALU control encodings and RV32I opcode constants for the issue stage and the ALU.
package alu_issue_pkg;

  localparam int unsigned ALU_CTRL_WIDTH = 3;

  typedef enum logic [ALU_CTRL_WIDTH-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_ctrl_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;

  // funct3 values that the ALU implements directly (shifts are excluded)
  function automatic logic funct3_supported(input logic [2:0] f3);
    return (f3 == ALU_ADD) || (f3 == ALU_SLT) || (f3 == ALU_SLTU) ||
           (f3 == ALU_XOR) || (f3 == ALU_OR)  || (f3 == ALU_AND);
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of OP / OP-IMM (and optionally LUI, macro ALU_ISSUE_LUI_EN)
// into ALU operand selects, immediate and control.
module alu_issue_decode
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [31:0]               instr,
  output logic                      legal,
  output logic [ALU_CTRL_WIDTH-1:0] ctrl,
  output logic                      use_imm,
  output logic [XLEN-1:0]           imm,
  output logic                      zero_din0,
  output logic [REG_ADDR_WIDTH-1:0] rd
);

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [6:0]     funct7;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] u_imm;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[7 +: REG_ADDR_WIDTH];
  assign i_imm  = XLEN'($signed(instr[31:20]));
  assign u_imm  = XLEN'($signed({instr[31:12], 12'b0}));

  always_comb begin
    legal     = 1'b0;
    ctrl      = ALU_ADD;
    use_imm   = 1'b0;
    imm       = i_imm;
    zero_din0 = 1'b0;
    case (opcode)
      OP: begin
        legal = funct3_supported(funct3) && (funct7 == FUNCT7_BASE);
        ctrl  = funct3;
      end
      OP_IMM: begin
        legal   = funct3_supported(funct3);
        ctrl    = funct3;
        use_imm = 1'b1;
      end
      LUI: begin
        // operand selects are set in both builds; only legality depends on the macro
`ifdef ALU_ISSUE_LUI_EN
        legal     = 1'b1;
`else
        legal     = 1'b0;
`endif
        ctrl      = ALU_ADD;
        use_imm   = 1'b1;
        imm       = u_imm;
        zero_din0 = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage for the registered-output ALU: operand/control issue register, writeback
// tracking two edges after acceptance, illegal pulse and counter. Optional LUI: ALU_ISSUE_LUI_EN.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [XLEN-1:0]           rs1_data,
  input  logic [XLEN-1:0]           rs2_data,
  input  logic                      hold,
  output logic [XLEN-1:0]           alu_din_0,
  output logic [XLEN-1:0]           alu_din_1,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      illegal,
  output logic [7:0]                illegal_cnt
);

  logic                      dec_legal;
  logic [ALU_CTRL_WIDTH-1:0] dec_ctrl;
  logic                      dec_use_imm;
  logic [XLEN-1:0]           dec_imm;
  logic                      dec_zero_din0;
  logic [REG_ADDR_WIDTH-1:0] dec_rd;

  logic                      accept;
  logic                      issue;
  logic                      reject;
  logic                      iss_valid;
  logic [REG_ADDR_WIDTH-1:0] iss_rd;

  assign in_ready = !hold;
  assign rs1_addr = in_instr[15 +: REG_ADDR_WIDTH];
  assign rs2_addr = in_instr[20 +: REG_ADDR_WIDTH];

  alu_issue_decode #(
    .XLEN           (XLEN),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_decode (
    .instr     (in_instr),
    .legal     (dec_legal),
    .ctrl      (dec_ctrl),
    .use_imm   (dec_use_imm),
    .imm       (dec_imm),
    .zero_din0 (dec_zero_din0),
    .rd        (dec_rd)
  );

  assign accept = in_valid && in_ready;
  assign issue  = accept && dec_legal;
  assign reject = accept && !dec_legal;

  // Issue register: only a legal acceptance reloads operands; otherwise the ALU
  // recomputes the stale value, which is never written back.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      alu_din_0 <= '0;
      alu_din_1 <= '0;
      alu_ctrl  <= ALU_ADD;
      iss_rd    <= '0;
      iss_valid <= 1'b0;
    end else begin
      iss_valid <= issue && (dec_rd != '0);
      if (issue) begin
        alu_din_0 <= dec_zero_din0 ? '0 : rs1_data;
        alu_din_1 <= dec_use_imm ? dec_imm : rs2_data;
        alu_ctrl  <= dec_ctrl;
        iss_rd    <= dec_rd;
      end
    end
  end

  // Writeback stage lines up with the ALU's registered result
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
    end else begin
      wb_valid <= iss_valid;
      wb_rd    <= iss_rd;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      illegal <= reject;
      if (reject && (illegal_cnt != '1)) illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed cases plus randomized instruction stream
// checked against an instruction-level reference model and a behavioural ALU.
`timescale 1ns/1ps
module tb_alu_issue;

`ifdef ALU_ISSUE_LUI_EN
  localparam bit LUI_EN = 1'b1;
`else
  localparam bit LUI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nreset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        hold;
  logic [31:0] alu_din_0, alu_din_1;
  logic [2:0]  alu_ctrl;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  alu_issue #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .hold(hold),
    .alu_din_0(alu_din_0), .alu_din_1(alu_din_1), .alu_ctrl(alu_ctrl),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] a, b, res;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [7:0]  cnt;
  } exp_t;

  exp_t iss_q[$];
  exp_t wb_q[$];
  exp_t ill_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int model_cnt = 0;
  logic [31:0] alu_res;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      3'd0: return x + y;
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd6: return x | y;
      3'd7: return x & y;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Behavioural registered-output ALU fed by the DUT's issue register
  always @(posedge clk) alu_res <= alu_fn(alu_ctrl, alu_din_0, alu_din_1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Instruction-level reference: what an accepted instruction must do
  task automatic model_accept(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        ok;
    exp_t        e;
    opc = ins[6:0];
    f3  = ins[14:12];
    ok  = 1'b0;
    e.a = a;
    e.b = b;
    e.op = f3;
    if (opc == 7'b0110011) begin
      ok = (ins[31:25] == 7'd0) && (f3 != 3'd1) && (f3 != 3'd5);
    end else if (opc == 7'b0010011) begin
      ok  = (f3 != 3'd1) && (f3 != 3'd5);
      e.b = {{20{ins[31]}}, ins[31:20]};
    end else if (opc == 7'b0110111) begin
      ok   = LUI_EN;
      e.a  = 32'd0;
      e.b  = {ins[31:12], 12'h000};
      e.op = 3'd0;
    end
    e.cyc = cyc + 1;
    e.rd  = ins[11:7];
    e.res = alu_fn(e.op, e.a, e.b);
    e.cnt = 8'(model_cnt);
    if (ok) begin
      iss_q.push_back(e);
      if (e.rd != 5'd0) begin
        e.cyc = cyc + 2;
        wb_q.push_back(e);
      end
    end else begin
      if (model_cnt < 255) model_cnt++;
      e.cnt = 8'(model_cnt);
      ill_q.push_back(e);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic h);
    @(posedge clk);
    #2;
    in_valid = v;
    in_instr = ins;
    rs1_data = a;
    rs2_data = b;
    hold     = h;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, !h});
    if (v) begin
      chk("rs1_addr", {27'd0, rs1_addr}, {27'd0, ins[19:15]});
      chk("rs2_addr", {27'd0, rs2_addr}, {27'd0, ins[24:20]});
    end
    if (v && !h) model_accept(ins, a, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_din0"}, alu_din_0, 32'd0);
    chk({tag, "_din1"}, alu_din_1, 32'd0);
    chk({tag, "_ctrl"}, {29'd0, alu_ctrl}, 32'd0);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, illegal_cnt}, 32'd0);
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Monitor: compares whatever the DUT presents against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (nreset === 1'b1) begin
      if (wb_valid) begin
        if (wb_q.size() == 0 || wb_q[0].cyc != cyc) begin
          fail_now("wb_unexpected");
        end else begin
          e = wb_q.pop_front();
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          chk("alu_result", alu_res, e.res);
        end
      end else if (wb_q.size() != 0 && wb_q[0].cyc <= cyc) begin
        void'(wb_q.pop_front());
        fail_now("wb_missing");
      end
      if (iss_q.size() != 0 && iss_q[0].cyc == cyc) begin
        e = iss_q.pop_front();
        chk("alu_din_0", alu_din_0, e.a);
        chk("alu_din_1", alu_din_1, e.b);
        chk("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, e.op});
      end
      if (illegal) begin
        if (ill_q.size() == 0 || ill_q[0].cyc != cyc) begin
          fail_now("illegal_unexpected");
        end else begin
          e = ill_q.pop_front();
          chk("illegal_cnt", {24'd0, illegal_cnt}, {24'd0, e.cnt});
        end
      end else if (ill_q.size() != 0 && ill_q[0].cyc <= cyc) begin
        void'(ill_q.pop_front());
        fail_now("illegal_missing");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  opc;
    int          r;
    nreset   = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    rs1_data = '0;
    rs2_data = '0;
    hold     = 1'b0;
    #12;
    chk_reset_outputs("reset");
    #1 nreset = 1'b1;
    idle(2);

    // ADD x3,x1,x2 : 5 + 7
    drive(1'b1, r_type(7'd0, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 1'b0);
    idle(3);

    // ADDI x4,x1,-1 then SLTIU x5,x1,-1 back to back
    drive(1'b1, i_type(12'hFFF, 5'd1, 3'd0, 5'd4), 32'd5, 32'd99, 1'b0);
    drive(1'b1, i_type(12'hFFF, 5'd1, 3'd3, 5'd5), 32'd5, 32'd99, 1'b0);
    idle(3);

    // SUB and SLL are illegal
    drive(1'b1, r_type(7'b0100000, 5'd2, 5'd1, 3'd0, 5'd6), 32'd9, 32'd1, 1'b0);
    drive(1'b1, r_type(7'd0, 5'd2, 5'd1, 3'd1, 5'd6), 32'd9, 32'd1, 1'b0);
    idle(2);
    chk("cnt_after_two", {24'd0, illegal_cnt}, 32'd2);

    for (int i = 0; i < 300; i++) begin
      ins = $urandom() & 32'hFFFF_FF80;
      drive(1'b1, ins, $urandom(), $urandom(), 1'b0);
    end
    idle(2);
    chk("cnt_saturated", {24'd0, illegal_cnt}, 32'd255);

    // hold with in_valid: no acceptance, earlier op still writes back
    drive(1'b1, r_type(7'd0, 5'd3, 5'd4, 3'd6, 5'd8), 32'h00F0, 32'h0F00, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b1, r_type(7'd0, 5'd3, 5'd4, 3'd4, 5'd9), 32'h1234, 32'h00FF, 1'b1);
    drive(1'b1, r_type(7'd0, 5'd3, 5'd4, 3'd4, 5'd9), 32'h1234, 32'h00FF, 1'b0);
    idle(3);

    // ADDI x0,x0,0 : issues, no writeback, not illegal
    drive(1'b1, i_type(12'd0, 5'd0, 3'd0, 5'd0), 32'd0, 32'd0, 1'b0);
    idle(3);

    // legal accept followed by a reset pulse in the next cycle
    drive(1'b1, r_type(7'd0, 5'd2, 5'd1, 3'd7, 5'd7), 32'hFFFF, 32'h0F0F, 1'b0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    nreset   = 1'b0;
    iss_q.delete();
    wb_q.delete();
    ill_q.delete();
    model_cnt = 0;
    #1;
    chk_reset_outputs("midreset");
    #1 nreset = 1'b1;
    idle(3);

    // LUI x6,0x12345
    drive(1'b1, {20'h12345, 5'd6, 7'b0110111}, $urandom(), $urandom(), 1'b0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      opc = 7'b0110011;
      else if (r < 8) opc = 7'b0010011;
      else if (r == 8) opc = 7'b0110111;
      else            opc = 7'($urandom());
      ins = $urandom();
      ins[6:0] = opc;
      if (opc == 7'b0110011) ins[31:25] = ($urandom_range(0, 5) == 0) ? 7'b0100000 : 7'd0;
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      drive($urandom_range(0, 4) != 0, ins,
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom(),
            $urandom(), $urandom_range(0, 4) == 0);
    end
    idle(4);

    chk("wb_q_drained", wb_q.size(), 32'd0);
    chk("iss_q_drained", iss_q.size(), 32'd0);
    chk("ill_q_drained", ill_q.size(), 32'd0);
    chk("final_cnt", {24'd0, illegal_cnt}, 32'(model_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage that drives the 3-bit-control, registered-output integer ALU. It accepts RV32I OP and OP-IMM instructions with their register-file operands and decodes them into ALU operands and control. It registers the operands for the ALU and tracks each issued operation, so that a writeback strobe and destination register line up with the ALU result two edges after acceptance. It sits between the register-read logic and the ALU/writeback port of the core.

## Interface
- XLEN, 32, operand/result width
- REG_ADDR_WIDTH, 5, register index width
- clk  in  1  clock; every register samples on the rising edge
- nreset  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage accepts; equals !hold
- in_instr  in  32  instruction word
- rs1_addr, rs2_addr  out  REG_ADDR_WIDTH  in_instr[19:15] / [24:20], combinational
- rs1_data, rs2_data  in  XLEN  register-file data for rs1_addr/rs2_addr, same cycle
- hold  in  1  downstream stall request
- alu_din_0, alu_din_1  out  XLEN  registered ALU operands
- alu_ctrl  out  3  registered ALU control
- wb_valid  out  1  ALU result valid this cycle, write to wb_rd
- wb_rd  out  REG_ADDR_WIDTH  destination of current ALU result
- illegal  out  1  one-cycle pulse: accepted instruction unsupported
- illegal_cnt  out  8  saturating count of illegal instructions

## Operation
- Accept when in_valid && in_ready.
- Decode opcode in_instr[6:0], funct3 [14:12], funct7 [31:25].
- Supported funct3 values map directly to alu_ctrl: 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
- OP (0110011): funct7 must be 0000000; din_0 = rs1_data, din_1 = rs2_data.
- OP-IMM (0010011): din_0 = rs1_data; din_1 = sign-extended in_instr[31:20].
- Unsupported instructions are illegal and are not issued:
  - funct3 001 or 101 (shifts)
  - OP with any other funct7 (e.g. SUB, 0100000)
  - any other opcode
- rd = in_instr[11:7]. rd == 0 issues normally (operands and ctrl loaded) but suppresses wb_valid; this is not illegal.
- Operand registers update only on a legal acceptance. Otherwise they keep their value; the ALU keeps recomputing the stale value, which is harmless because no wb_valid is produced.
- illegal_cnt increments on each illegal acceptance and saturates at 255.

## Timing
- Reset values: alu_din_0/1 = 0, alu_ctrl = 000, wb_valid = 0, wb_rd = 0, illegal = 0, illegal_cnt = 0.
- in_ready is combinational !hold. Accept in cycle T with hold = 1 never happens.
- Legal accept in cycle T:
  - operands/ctrl are valid in T+1 (issue register, internal iss_valid/iss_rd);
  - the ALU samples at the end of T+1;
  - wb_valid = 1 with wb_rd in T+2, for exactly one cycle.
- Back-to-back acceptance gives one wb_valid per cycle. Throughput is 1 instruction/cycle.
- Illegal accept in cycle T: illegal = 1 in T+1; iss_valid = 0 in T+1; no wb_valid in T+2.
- Bubble (no acceptance) in T: iss_valid = 0 in T+1, and wb_valid = 0 in T+2.
- hold does not stall operations already issued; they complete to wb_valid.
- nreset asserted mid-operation: all in-flight operations are discarded. wb_valid stays 0 until two cycles after the first post-reset acceptance.

## Configuration
- ALU_ISSUE_LUI_EN defined:
  - LUI (0110111) is legal;
  - issued as ADD with din_0 = 0, din_1 = {in_instr[31:12], 12'b0};
  - rd rules as above.
- Undefined: LUI is illegal.

## Structure
- Shared package holds:
  - ALU_CTRL_WIDTH = 3;
  - ctrl encodings (ADD/SLT/SLTU/XOR/OR/AND);
  - opcode constants OP, OP_IMM, LUI.
- The ALU uses the same package.
- One combinational sub-module, alu_issue_decode: instr -> {legal, ctrl, use_imm, imm, zero_din0, rd}.
- Top level holds the issue register, the wb pipeline register and illegal_cnt.

## Test plan
- ADD x3,x1,x2 with rs1 = 5, rs2 = 7, accepted in T -> alu_ctrl = 000, din = 5/7 in T+1; wb_valid = 1, wb_rd = 3, ALU result = 12 in T+2.
- ADDI x4,x1,-1 (imm 0xFFF), then SLTIU x5,x1,-1 back-to-back with rs1 = 5:
  - din_1 = 0xFFFFFFFF for both;
  - wb_valid in consecutive cycles, rd = 4 then 5;
  - results 4 then 1.
- SUB (funct7 0100000) and SLL -> illegal pulses, illegal_cnt = 2, no wb_valid. Then 300 illegal instructions -> illegal_cnt = 255.
- hold = 1 for 3 cycles with in_valid = 1:
  - in_ready = 0, no acceptance;
  - a previously issued op still produces wb_valid;
  - acceptance resumes the cycle hold drops.
- ADDI x0,x0,0 -> no wb_valid, illegal = 0. nreset pulsed in T+1 after a legal accept -> no wb_valid in T+2, all outputs 0.
- LUI x6,0x12345 -> with ALU_ISSUE_LUI_EN: wb_valid, wb_rd = 6, result 0x12345000. Without the macro: illegal = 1.
